// File: rtl/scene_sequencer.sv
// scene_sequencer: clears the frame, then draws a table of Reuleaux triangles on a shared engine
//
// Ports:
//   clk, rst_n                      clock and asynchronous active-low reset
//   start / done                    level scene request and its completion flag
//   bg_colour                       clear colour, latched when a scene starts
//   cfg_we/addr/x/y/d/colour        shape table write port (IDLE or DONE only)
//   cfg_count                       shapes to draw, latched and saturated at scene start
//   fs_start/fs_done/fs_colour      fillscreen handshake and colour
//   fs_vga_*                        fillscreen plot bus
//   ru_start/ru_done/ru_*           reuleaux handshake and operands
//   ru_vga_*                        reuleaux plot bus
//   vga_x/y/colour/plot             muxed plot bus to the VGA adapter
//
// Build option: define SEQ_PLOT_CLIP_EN to suppress plots outside the 160x120 frame.
module scene_sequencer #(
    parameter int MAX_SHAPES = 4,
    localparam int AW = (MAX_SHAPES > 1) ? $clog2(MAX_SHAPES) : 1,
    localparam int CW = $clog2(MAX_SHAPES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          done,
    input  logic [2:0]    bg_colour,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [7:0]    cfg_x,
    input  logic [6:0]    cfg_y,
    input  logic [7:0]    cfg_d,
    input  logic [2:0]    cfg_colour,
    input  logic [CW-1:0] cfg_count,
    output logic          fs_start,
    input  logic          fs_done,
    output logic [2:0]    fs_colour,
    input  logic [7:0]    fs_vga_x,
    input  logic [6:0]    fs_vga_y,
    input  logic [2:0]    fs_vga_colour,
    input  logic          fs_vga_plot,
    output logic          ru_start,
    input  logic          ru_done,
    output logic [7:0]    ru_centre_x,
    output logic [6:0]    ru_centre_y,
    output logic [7:0]    ru_diameter,
    output logic [2:0]    ru_colour,
    input  logic [7:0]    ru_vga_x,
    input  logic [6:0]    ru_vga_y,
    input  logic [2:0]    ru_vga_colour,
    input  logic          ru_vga_plot,
    output logic [7:0]    vga_x,
    output logic [6:0]    vga_y,
    output logic [2:0]    vga_colour,
    output logic          vga_plot
);
    typedef enum logic [2:0] {IDLE, CLEAR, CLEAR_REL, LOAD, DRAW, DRAW_REL, DONE} state_t;
    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [7:0] d;
        logic [2:0] c;
    } shape_t;
    state_t        state;
    shape_t        shapes [MAX_SHAPES];
    logic [CW-1:0] count_q;
    logic [AW-1:0] idx;
    logic [7:0]    hold_x;
    logic [6:0]    hold_y;
    logic [2:0]    hold_colour;
    logic          route_fs, route_ru, plot_raw;
    assign route_fs = (state == CLEAR) || (state == CLEAR_REL);
    assign route_ru = (state == LOAD) || (state == DRAW) || (state == DRAW_REL);
    // Live inputs pass straight through while an engine owns the bus; otherwise the last routed position is held.
    always_comb begin
        vga_x      = route_fs ? fs_vga_x      : route_ru ? ru_vga_x      : hold_x;
        vga_y      = route_fs ? fs_vga_y      : route_ru ? ru_vga_y      : hold_y;
        vga_colour = route_fs ? fs_vga_colour : route_ru ? ru_vga_colour : hold_colour;
        plot_raw   = route_fs ? fs_vga_plot   : route_ru ? ru_vga_plot   : 1'b0;
    end
`ifdef SEQ_PLOT_CLIP_EN
    assign vga_plot = plot_raw && (vga_x < 8'd160) && (vga_y < 7'd120);
`else
    assign vga_plot = plot_raw;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            done        <= 1'b0;
            fs_start    <= 1'b0;
            ru_start    <= 1'b0;
            fs_colour   <= '0;
            ru_centre_x <= '0;
            ru_centre_y <= '0;
            ru_diameter <= '0;
            ru_colour   <= '0;
            count_q     <= '0;
            idx         <= '0;
            hold_x      <= '0;
            hold_y      <= '0;
            hold_colour <= '0;
            for (int i = 0; i < MAX_SHAPES; i++) shapes[i] <= '0;
        end else begin
            if ((state == IDLE || state == DONE) && cfg_we && 32'(cfg_addr) < MAX_SHAPES)
                shapes[cfg_addr] <= '{cfg_x, cfg_y, cfg_d, cfg_colour};
            if (route_fs || route_ru) begin
                hold_x      <= vga_x;
                hold_y      <= vga_y;
                hold_colour <= vga_colour;
            end
            case (state)
                IDLE: if (start) begin
                    fs_colour <= bg_colour;
                    count_q   <= (32'(cfg_count) > MAX_SHAPES) ? CW'(MAX_SHAPES) : cfg_count;
                    fs_start  <= 1'b1;
                    state     <= CLEAR;
                end
                CLEAR: if (fs_done) begin
                    fs_start <= 1'b0;
                    state    <= CLEAR_REL;
                end
                CLEAR_REL: if (!start) state <= IDLE;
                else if (count_q == '0) begin
                    done  <= 1'b1;
                    state <= DONE;
                end else begin
                    idx <= '0;
                    {ru_centre_x, ru_centre_y, ru_diameter, ru_colour} <= shapes[0];
                    state <= LOAD;
                end
                LOAD: if (!start) state <= IDLE;
                else begin
                    ru_start <= 1'b1;
                    state    <= DRAW;
                end
                DRAW: if (ru_done) begin
                    ru_start <= 1'b0;
                    state    <= DRAW_REL;
                end
                DRAW_REL: if (!start) state <= IDLE;
                else if (CW'(idx) + CW'(1) == count_q) begin
                    done  <= 1'b1;
                    state <= DONE;
                end else begin
                    idx <= idx + AW'(1);
                    {ru_centre_x, ru_centre_y, ru_diameter, ru_colour} <= shapes[idx + AW'(1)];
                    state <= LOAD;
                end
                DONE: if (!start) begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scene_sequencer.sv
// tb_scene_sequencer: directed checks of scene_sequencer handshakes, table, saturation, abort, reset and plot mux
module tb_scene_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       done;
    logic [2:0] bg_colour = '0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = '0;
    logic [7:0] cfg_x = '0;
    logic [6:0] cfg_y = '0;
    logic [7:0] cfg_d = '0;
    logic [2:0] cfg_colour = '0;
    logic [2:0] cfg_count = '0;
    logic       fs_start;
    logic       fs_done = 1'b0;
    logic [2:0] fs_colour;
    logic [7:0] fs_vga_x = '0;
    logic [6:0] fs_vga_y = '0;
    logic [2:0] fs_vga_colour = '0;
    logic       fs_vga_plot = 1'b0;
    logic       ru_start;
    logic       ru_done = 1'b0;
    logic [7:0] ru_centre_x;
    logic [6:0] ru_centre_y;
    logic [7:0] ru_diameter;
    logic [2:0] ru_colour;
    logic [7:0] ru_vga_x = '0;
    logic [6:0] ru_vga_y = '0;
    logic [2:0] ru_vga_colour = '0;
    logic       ru_vga_plot = 1'b0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    int total = 0;
    int bad = 0;
    int n, ovl;
    logic prev;

    scene_sequencer #(.MAX_SHAPES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .done(done), .bg_colour(bg_colour),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_d(cfg_d),
        .cfg_colour(cfg_colour), .cfg_count(cfg_count),
        .fs_start(fs_start), .fs_done(fs_done), .fs_colour(fs_colour),
        .fs_vga_x(fs_vga_x), .fs_vga_y(fs_vga_y), .fs_vga_colour(fs_vga_colour), .fs_vga_plot(fs_vga_plot),
        .ru_start(ru_start), .ru_done(ru_done), .ru_centre_x(ru_centre_x), .ru_centre_y(ru_centre_y),
        .ru_diameter(ru_diameter), .ru_colour(ru_colour),
        .ru_vga_x(ru_vga_x), .ru_vga_y(ru_vga_y), .ru_vga_colour(ru_vga_colour), .ru_vga_plot(ru_vga_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] x, input logic [6:0] y, input logic [7:0] d, input logic [2:0] c);
        cfg_we = 1'b1; cfg_addr = a; cfg_x = x; cfg_y = y; cfg_d = d; cfg_colour = c;
        tick();
        cfg_we = 1'b0;
    endtask

    // From IDLE with start high: CLEAR until fs_done, ending in CLEAR_REL.
    task automatic run_clear();
        tick();
        chk("clr_fs_start_hi", fs_start, 1);
        fs_done = 1'b1;
        tick();
        fs_done = 1'b0;
        chk("clr_fs_start_lo", fs_start, 0);
    endtask

    // From a release state: LOAD, DRAW, DRAW_REL with operand check.
    task automatic draw_one(input logic [7:0] x, input logic [6:0] y, input logic [7:0] d, input logic [2:0] c);
        tick();
        chk("load_ops", {ru_centre_x, ru_centre_y, ru_diameter, ru_colour}, {x, y, d, c});
        chk("load_ru_start_lo", ru_start, 0);
        tick();
        chk("draw_ru_start_hi", ru_start, 1);
        ru_done = 1'b1;
        tick();
        ru_done = 1'b0;
        chk("rel_ru_start_lo", ru_start, 0);
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_done", done, 0);
        chk("rst_fs_start", fs_start, 0);
        chk("rst_ru_start", ru_start, 0);
        chk("rst_vga_plot", vga_plot, 0);
        chk("rst_ops", {ru_centre_x, ru_centre_y, ru_diameter, ru_colour, fs_colour}, 0);
        rst_n = 1'b1;
        tick();
        // Empty scene: clear only, with plot routing from fillscreen.
        fs_vga_x = 8'd12; fs_vga_y = 7'd34; fs_vga_colour = 3'd5; fs_vga_plot = 1'b1;
        ru_vga_x = 8'd99; ru_vga_y = 7'd11; ru_vga_colour = 3'd1;
        #1 chk("idle_plot_blocked", vga_plot, 0);
        cfg_count = 3'd0; bg_colour = 3'd0; start = 1'b1;
        tick();
        chk("t1_fs_start", fs_start, 1);
        chk("t1_ru_start", ru_start, 0);
        chk("t1_route_fs", {vga_x, vga_y, vga_colour, vga_plot}, {8'd12, 7'd34, 3'd5, 1'b1});
        fs_vga_x = 8'd13;
        #1 chk("t1_zero_latency", vga_x, 13);
        tick();
        chk("t1_fs_start_held", fs_start, 1);
        fs_done = 1'b1;
        tick();
        fs_done = 1'b0;
        chk("t1_fs_start_drop", fs_start, 0);
        chk("t1_done_early", done, 0);
        tick();
        chk("t1_done", done, 1);
        chk("t1_ru_never", ru_start, 0);
        chk("t1_hold", {vga_x, vga_plot}, {8'd13, 1'b0});
        start = 1'b0;
        tick();
        chk("t1_done_clr", done, 0);
        // Two shapes, with a rejected table write during DRAW.
        wr(2'd0, 8'd80, 7'd60, 8'd80, 3'b010);
        wr(2'd1, 8'd40, 7'd30, 8'd20, 3'b100);
        cfg_count = 3'd2; bg_colour = 3'd3; start = 1'b1;
        run_clear();
        chk("t2_fs_colour", fs_colour, 3);
        tick();
        chk("t2_load0_ops", {ru_centre_x, ru_centre_y, ru_diameter, ru_colour}, {8'd80, 7'd60, 8'd80, 3'd2});
        tick();
        chk("t2_draw0_start", ru_start, 1);
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_x = 8'd1; cfg_y = 7'd1; cfg_d = 8'd1; cfg_colour = 3'd1;
        tick();
        cfg_we = 1'b0;
        chk("t2_draw0_stable", {ru_centre_x, ru_diameter, ru_start}, {8'd80, 8'd80, 1'b1});
        ru_done = 1'b1;
        tick();
        ru_done = 1'b0;
        chk("t2_rel_start", ru_start, 0);
        draw_one(8'd40, 7'd30, 8'd20, 3'd4);
        chk("t2_done_late", done, 0);
        tick();
        chk("t2_done", done, 1);
        start = 1'b0;
        tick();
        cfg_count = 3'd1; start = 1'b1;
        run_clear();
        draw_one(8'd80, 7'd60, 8'd80, 3'd2);
        tick();
        chk("t4_done", done, 1);
        start = 1'b0;
        tick();
        // Saturation: count 7 draws exactly the 4 table entries.
        cfg_count = 3'd7; start = 1'b1;
        run_clear();
        n = 0; ovl = 0; prev = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            tick();
            if (ru_start && !prev) n++;
            if (ru_start && fs_start) ovl++;
            ru_done = ru_start;
            prev = ru_start;
        end
        ru_done = 1'b0;
        chk("t3_draws", n, 4);
        chk("t3_done", done, 1);
        chk("t3_overlap", ovl, 0);
        chk("t3_last_ops", {ru_centre_x, ru_diameter}, 0);
        start = 1'b0;
        tick();
        // Abort during the second DRAW.
        cfg_count = 3'd2; start = 1'b1;
        run_clear();
        draw_one(8'd80, 7'd60, 8'd80, 3'd2);
        tick();
        tick();
        chk("t5_draw1", ru_start, 1);
        start = 1'b0;
        tick();
        chk("t5_hs_kept", ru_start, 1);
        ru_done = 1'b1;
        tick();
        ru_done = 1'b0;
        chk("t5_rel", {ru_start, done}, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_quiet", {ru_start, fs_start, done}, 0);
        end
        // Restart proves IDLE, then asynchronous reset mid-CLEAR.
        start = 1'b1;
        tick();
        chk("t6_restart", fs_start, 1);
        rst_n = 1'b0;
        #2;
        chk("t6_async_rst", {fs_start, ru_start, done, vga_plot}, 0);
        chk("t6_async_ops", {ru_centre_x, ru_centre_y, ru_diameter, ru_colour, fs_colour}, 0);
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        // Plot routing from reuleaux, with optional clipping.
        wr(2'd0, 8'd150, 7'd100, 8'd40, 3'd7);
        cfg_count = 3'd1; start = 1'b1;
        run_clear();
        tick();
        ru_vga_x = 8'd170; ru_vga_y = 7'd10; ru_vga_colour = 3'd6; ru_vga_plot = 1'b1;
        #1;
        chk("t7_route_ru", {vga_x, vga_colour}, {8'd170, 3'd6});
`ifdef SEQ_PLOT_CLIP_EN
        chk("t7_clip_x", vga_plot, 0);
`else
        chk("t7_clip_x", vga_plot, 1);
`endif
        ru_vga_x = 8'd100; ru_vga_y = 7'd125;
        #1;
`ifdef SEQ_PLOT_CLIP_EN
        chk("t7_clip_y", vga_plot, 0);
`else
        chk("t7_clip_y", vga_plot, 1);
`endif
        ru_vga_y = 7'd119;
        #1 chk("t7_inside", vga_plot, 1);
        tick();
        ru_done = 1'b1;
        tick();
        ru_done = 1'b0;
        tick();
        chk("t7_done", {done, vga_plot}, {1'b1, 1'b0});
        start = 1'b0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule
